// File: rtl/audio_pkg.sv
// Shared audio definitions used by the PCM producer, the sample history and the beamformer.
package audio_pkg;

  localparam int PCM_W = 19;

  typedef logic [PCM_W-1:0] pcm_sample_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_HOLD = 1'b1
  } rd_state_t;

endpackage

// File: rtl/pcm_ring_ram.sv
// Sample-history storage: one write port and one registered read port.
// A read and a write to the same address in one cycle returns the old contents.
module pcm_ring_ram #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage array; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register samples the array before this cycle's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/pcm_delay_reader.sv
// Per-mic PCM history with random-access "N samples ago" reads for the tap sequencer.
// Holds the write pointer, fill level, response register and request handshake.
module pcm_delay_reader
  import audio_pkg::*;
#(
  parameter int DATA_W = PCM_W,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pcm_data,
  input  logic              pcm_valid,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [AW-1:0]     rd_delay,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_underflow
);

  localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [AW-1:0]     wr_ptr_r;
  logic [AW:0]       fill_r;
  rd_state_t         state_r;
  logic              rd_underflow_r;
  logic              accept_s;
  logic              under_s;
  logic [AW-1:0]     rd_idx_s;
  logic [DATA_W-1:0] ram_q_s;

  assign rd_valid     = (state_r == RD_HOLD);
  assign rd_req_ready = !rd_valid || rd_ready;
  assign accept_s     = rd_req_valid && rd_req_ready;
  // Index and range check both use the pre-write pointer and fill of this cycle.
  assign rd_idx_s     = wr_ptr_r - PTR_ONE - rd_delay;
  assign under_s      = ({1'b0, rd_delay} >= fill_r);
  assign rd_underflow = rd_underflow_r;
  assign rd_data      = (rd_valid && !rd_underflow_r) ? ram_q_s : '0;

  pcm_ring_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (pcm_valid),
    .waddr (wr_ptr_r),
    .wdata (pcm_data),
    .re    (accept_s),
    .raddr (rd_idx_s),
    .rdata (ram_q_s)
  );

  // Write pointer and saturating fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      fill_r   <= '0;
    end else if (pcm_valid) begin
      wr_ptr_r <= wr_ptr_r + PTR_ONE;
      fill_r   <= (fill_r == FILL_FULL) ? fill_r : fill_r + (AW+1)'(1);
    end
  end

  // Response register: HOLD while a result waits for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= RD_IDLE;
      rd_underflow_r <= 1'b0;
    end else begin
      case (state_r)
        RD_IDLE: begin
          if (accept_s) begin
            state_r        <= RD_HOLD;
            rd_underflow_r <= under_s;
          end
        end
        RD_HOLD: begin
          if (accept_s) begin
            rd_underflow_r <= under_s;
          end else if (rd_ready) begin
            state_r        <= RD_IDLE;
            rd_underflow_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= RD_IDLE;
          rd_underflow_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_delay_reader.sv
// Directed-vector bench for pcm_delay_reader with hand-computed expected samples.
module tb_pcm_delay_reader;

  localparam int DATA_W = 19;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] pcm_data;
  logic              pcm_valid;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [AW-1:0]     rd_delay;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_underflow;

  int checks_cnt;
  int fail_cnt;

  pcm_delay_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcm_data     (pcm_data),
    .pcm_valid    (pcm_valid),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_delay     (rd_delay),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_underflow (rd_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input string tag, input int data_v, input logic und_v);
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_data"}, {13'd0, rd_data}, data_v);
    check({tag, "_und"}, {31'd0, rd_underflow}, {31'd0, und_v});
  endtask

  initial begin
    checks_cnt   = 0;
    fail_cnt     = 0;
    rst          = 1'b1;
    pcm_data     = '0;
    pcm_valid    = 1'b0;
    rd_req_valid = 1'b0;
    rd_delay     = '0;
    rd_ready     = 1'b1;
    step();
    step();
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_data", {13'd0, rd_data}, 32'd0);
    check("rst_und", {31'd0, rd_underflow}, 32'd0);
    check("rst_req_ready", {31'd0, rd_req_ready}, 32'd1);
    rst = 1'b0;

    // 1: read before any write underflows
    rd_req_valid = 1'b1;
    rd_delay     = 5'd0;
    step();
    expect_resp("t1", 0, 1'b1);
    rd_req_valid = 1'b0;
    step();
    check("t1_idle", {31'd0, rd_valid}, 32'd0);

    // 2: write 1,2,3 then back-to-back reads
    pcm_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pcm_data = 19'(k);
      step();
    end
    pcm_valid    = 1'b0;
    rd_req_valid = 1'b1;
    for (int d = 0; d <= 3; d++) begin
      rd_delay = 5'(d);
      step();
      if (d < 3) expect_resp($sformatf("t2_d%0d", d), 3 - d, 1'b0);
      else       expect_resp("t2_d3", 0, 1'b1);
    end
    rd_req_valid = 1'b0;
    step();

    // 3: 40 samples 100..139, every delay in range
    pcm_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      pcm_data = 19'(100 + k);
      step();
    end
    pcm_valid    = 1'b0;
    rd_req_valid = 1'b1;
    for (int d = 0; d < DEPTH; d++) begin
      rd_delay = 5'(d);
      step();
      expect_resp($sformatf("t3_d%0d", d), 139 - d, 1'b0);
    end

    // 4: collision of write and oldest-slot read returns the old sample
    pcm_valid = 1'b1;
    pcm_data  = 19'd200;
    rd_delay  = 5'd31;
    step();
    expect_resp("t4_collide", 108, 1'b0);
    pcm_valid = 1'b0;
    rd_delay  = 5'd0;
    step();
    expect_resp("t4_new", 200, 1'b0);
    rd_delay = 5'd31;
    step();
    expect_resp("t4_oldest", 109, 1'b0);

    // 5: consumer stalls while writes continue
    rd_delay = 5'd0;
    step();
    expect_resp("t5_first", 200, 1'b0);
    rd_ready  = 1'b0;
    rd_delay  = 5'd1;
    pcm_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pcm_data = 19'(300 + k);
      #1;
      check($sformatf("t5_req_ready%0d", k), {31'd0, rd_req_ready}, 32'd0);
      step();
      expect_resp($sformatf("t5_hold%0d", k), 200, 1'b0);
    end
    pcm_valid = 1'b0;
    rd_ready  = 1'b1;
    #1;
    check("t5_resume_ready", {31'd0, rd_req_ready}, 32'd1);
    step();
    expect_resp("t5_resume", 303, 1'b0);
    rd_delay = 5'd5;
    step();
    expect_resp("t5_d5", 200, 1'b0);

    // 6: reset while a response is held on a full buffer
    rd_req_valid = 1'b0;
    rd_ready     = 1'b0;
    step();
    check("t6_held", {31'd0, rd_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, rd_valid}, 32'd0);
    check("t6_rst_data", {13'd0, rd_data}, 32'd0);
    step();
    rst          = 1'b0;
    rd_ready     = 1'b1;
    rd_req_valid = 1'b1;
    rd_delay     = 5'd0;
    step();
    expect_resp("t6_after", 0, 1'b1);
    rd_req_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
